// File: rtl/robin_mem_responder.sv
// rtl/robin_mem_responder.sv - robin bus memory responder with host load/dump sequencer
//
// Purpose: byte-wide RAM for the robin CPU with a registered read port and a
// write strobe, plus a sequencer that:
//   - holds the CPU in reset while the host streams a program in from address 0
//   - releases the CPU on host_start
//   - streams the CPU register dump out once the CPU halts
// Optional feature: define DUMP_CHECKSUM_EN to append one extra byte after the
// dump. That byte is the two's complement of the 8-bit sum of the dump bytes.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   mem_data_out        registered read data to CPU (1-cycle latency)
//   mem_data_in         CPU write data
//   mem_raddr           CPU read address
//   mem_waddr           CPU write address
//   mem_write           CPU write strobe
//   mem_ready           high while the CPU may access memory (RUN only)
//   cpu_reset           reset to CPU core
//   cpu_start_address   constant START_ADDR
//   cpu_halted          CPU halted flag
//   host_in_data        program byte stream, data
//   host_in_valid       program byte stream, valid
//   host_in_ready       program byte stream, ready
//   host_start          end load and start CPU; re-arm from DONE
//   host_out_data       dump byte stream, data
//   host_out_valid      dump byte stream, valid
//   host_out_ready      dump byte stream, ready
module robin_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned START_ADDR = 0,
  parameter int unsigned DUMP_BASE  = 2,
  parameter int unsigned DUMP_LEN   = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [7:0]            mem_data_out,
  input  logic [7:0]            mem_data_in,
  input  logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [ADDR_WIDTH-1:0] mem_waddr,
  input  logic                  mem_write,
  output logic                  mem_ready,
  output logic                  cpu_reset,
  output logic [ADDR_WIDTH-1:0] cpu_start_address,
  input  logic                  cpu_halted,
  input  logic [7:0]            host_in_data,
  input  logic                  host_in_valid,
  output logic                  host_in_ready,
  input  logic                  host_start,
  output logic [7:0]            host_out_data,
  output logic                  host_out_valid,
  input  logic                  host_out_ready
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam int unsigned CW    = $clog2(DUMP_LEN + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DUMP_RD,
    ST_DUMP_WAIT,
    ST_DUMP_OUT,
`ifdef DUMP_CHECKSUM_EN
    ST_DUMP_SUM,
`endif
    ST_DONE
  } state_t;

  logic [7:0]            ram [DEPTH];
  state_t                state;
  logic [ADDR_WIDTH-1:0] load_ptr;
  logic                  full;
  logic [CW-1:0]         dump_cnt;
`ifdef DUMP_CHECKSUM_EN
  logic [7:0]            dump_sum;
  logic [7:0]            sum_next;
`endif

  logic                  in_dump;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  host_accept;
  logic                  load_last;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [7:0]            ram_wdata;

  assign cpu_start_address = ADDR_WIDTH'(START_ADDR);

  always_comb begin
    in_dump     = (state == ST_DUMP_RD) || (state == ST_DUMP_WAIT) || (state == ST_DUMP_OUT);
    // Dump address wraps modulo the RAM depth.
    rd_addr     = in_dump ? (ADDR_WIDTH'(DUMP_BASE) + ADDR_WIDTH'(dump_cnt)) : mem_raddr;
    host_accept = (state == ST_IDLE) && host_in_valid && host_in_ready;
    // The byte at the top address sets full; load_ptr never wraps back over address 0.
    load_last   = host_accept && (&load_ptr);
    ram_we      = 1'b0;
    ram_waddr   = mem_waddr;
    ram_wdata   = mem_data_in;
    if (!reset) begin
      if (host_accept) begin
        ram_we    = 1'b1;
        ram_waddr = load_ptr;
        ram_wdata = host_in_data;
      end else if ((state == ST_RUN) && mem_write) begin
        ram_we    = 1'b1;
      end
    end
  end

`ifdef DUMP_CHECKSUM_EN
  assign sum_next = dump_sum + host_out_data;
`endif

  // RAM contents survive reset; a partial load stays in place.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_data_out <= 8'd0;
    end else begin
      mem_data_out <= ram[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      load_ptr       <= '0;
      full           <= 1'b0;
      dump_cnt       <= '0;
      cpu_reset      <= 1'b1;
      mem_ready      <= 1'b0;
      host_in_ready  <= 1'b0;
      host_out_valid <= 1'b0;
      host_out_data  <= 8'd0;
`ifdef DUMP_CHECKSUM_EN
      dump_sum       <= 8'd0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (host_accept) begin
            load_ptr <= load_ptr + ADDR_WIDTH'(1);
            if (load_last) begin
              full <= 1'b1;
            end
          end
          host_in_ready <= !host_start && !full && !load_last;
          if (host_start) begin
            state     <= ST_RUN;
            cpu_reset <= 1'b0;
            mem_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (cpu_halted) begin
            state     <= ST_DUMP_RD;
            dump_cnt  <= '0;
            mem_ready <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            dump_sum  <= 8'd0;
`endif
          end
        end
        ST_DUMP_RD: begin
          state <= ST_DUMP_WAIT;
        end
        ST_DUMP_WAIT: begin
          // mem_data_out now holds the byte addressed during DUMP_RD.
          host_out_data  <= mem_data_out;
          host_out_valid <= 1'b1;
          state          <= ST_DUMP_OUT;
        end
        ST_DUMP_OUT: begin
          if (host_out_ready) begin
            host_out_valid <= 1'b0;
            dump_cnt       <= dump_cnt + CW'(1);
`ifdef DUMP_CHECKSUM_EN
            dump_sum       <= sum_next;
`endif
            if ((dump_cnt + CW'(1)) < CW'(DUMP_LEN)) begin
              state <= ST_DUMP_RD;
            end else begin
`ifdef DUMP_CHECKSUM_EN
              host_out_data  <= 8'd0 - sum_next;
              host_out_valid <= 1'b1;
              state          <= ST_DUMP_SUM;
`else
              state     <= ST_DONE;
              cpu_reset <= 1'b1;
`endif
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        ST_DUMP_SUM: begin
          if (host_out_ready) begin
            host_out_valid <= 1'b0;
            state          <= ST_DONE;
            cpu_reset      <= 1'b1;
          end
        end
`endif
        ST_DONE: begin
          if (host_start) begin
            state         <= ST_IDLE;
            load_ptr      <= '0;
            full          <= 1'b0;
            host_in_ready <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_robin_mem_responder.sv
// tb/tb_robin_mem_responder.sv - self-checking bench for robin_mem_responder
module tb_robin_mem_responder;

  localparam int AW    = 9;
  localparam int DEPTH = 512;
  localparam int DBASE = 2;
  localparam int DLEN  = 64;
`ifdef DUMP_CHECKSUM_EN
  localparam int EXP_N = DLEN + 1;
`else
  localparam int EXP_N = DLEN;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    mem_data_out;
  logic [7:0]    mem_data_in = 8'd0;
  logic [AW-1:0] mem_raddr = '0;
  logic [AW-1:0] mem_waddr = '0;
  logic          mem_write = 1'b0;
  logic          mem_ready;
  logic          cpu_reset;
  logic [AW-1:0] cpu_start_address;
  logic          cpu_halted = 1'b0;
  logic [7:0]    host_in_data = 8'd0;
  logic          host_in_valid = 1'b0;
  logic          host_in_ready;
  logic          host_start = 1'b0;
  logic [7:0]    host_out_data;
  logic          host_out_valid;
  logic          host_out_ready = 1'b0;

  robin_mem_responder dut (
    .clk(clk), .reset(reset),
    .mem_data_out(mem_data_out), .mem_data_in(mem_data_in),
    .mem_raddr(mem_raddr), .mem_waddr(mem_waddr), .mem_write(mem_write),
    .mem_ready(mem_ready), .cpu_reset(cpu_reset), .cpu_start_address(cpu_start_address),
    .cpu_halted(cpu_halted),
    .host_in_data(host_in_data), .host_in_valid(host_in_valid), .host_in_ready(host_in_ready),
    .host_start(host_start),
    .host_out_data(host_out_data), .host_out_valid(host_out_valid), .host_out_ready(host_out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Behavioural model: a phase, the load pointer, a byte-array image of the RAM
  // with per-byte "known" flags, and a queue of expected dump bytes.
  localparam int P_LOAD = 0, P_RUN = 1, P_DUMP = 2, P_DONE = 3;
  int         phase = P_LOAD;
  int         lp = 0;
  bit         mfull = 1'b0;
  bit         after_rst = 1'b1;
  logic [7:0] mram [DEPTH];
  bit         mknown [DEPTH];
  logic [7:0] q [$];
  bit         exp_rd_v = 1'b0;
  logic [7:0] exp_rd = 8'd0;
  bit         prev_hold = 1'b0;
  logic [7:0] prev_data = 8'd0;
  int         rx_cnt = 0;
  logic [7:0] rx [128];

  always @(negedge clk) begin : model
    logic [7:0] e;
    int s;
    bit rdy_now;
    if (after_rst) begin
      chk("rst_cpu_reset", cpu_reset, 1);
      chk("rst_mem_ready", mem_ready, 0);
      chk("rst_in_ready", host_in_ready, 0);
      chk("rst_out_valid", host_out_valid, 0);
      chk("rst_out_data", host_out_data, 0);
      chk("rst_mem_data_out", mem_data_out, 0);
    end else begin
      case (phase)
        P_LOAD: begin
          chk("load_cpu_reset", cpu_reset, 1);
          chk("load_mem_ready", mem_ready, 0);
          chk("load_in_ready", host_in_ready, {31'd0, !mfull});
          chk("load_out_valid", host_out_valid, 0);
        end
        P_RUN: begin
          chk("run_cpu_reset", cpu_reset, 0);
          chk("run_mem_ready", mem_ready, 1);
          chk("run_in_ready", host_in_ready, 0);
          chk("run_out_valid", host_out_valid, 0);
        end
        P_DUMP: begin
          chk("dump_mem_ready", mem_ready, 0);
          chk("dump_in_ready", host_in_ready, 0);
          if (prev_hold) begin
            chk("dump_hold_valid", host_out_valid, 1);
            chk("dump_hold_data", host_out_data, prev_data);
          end
        end
        default: begin
          chk("done_cpu_reset", cpu_reset, 1);
          chk("done_mem_ready", mem_ready, 0);
          chk("done_in_ready", host_in_ready, 0);
          chk("done_out_valid", host_out_valid, 0);
        end
      endcase
      if (exp_rd_v) chk("mem_data_out", mem_data_out, exp_rd);
    end

    rdy_now   = !after_rst && (phase == P_LOAD) && !mfull;
    exp_rd_v  = 1'b0;
    prev_hold = 1'b0;
    if (reset) begin
      phase = P_LOAD;
      lp = 0;
      mfull = 1'b0;
      q.delete();
      after_rst = 1'b1;
    end else begin
      after_rst = 1'b0;
      if (phase != P_DUMP && mknown[mem_raddr]) begin
        exp_rd_v = 1'b1;
        exp_rd   = mram[mem_raddr];
      end
      case (phase)
        P_LOAD: begin
          if (host_in_valid && rdy_now) begin
            if (lp == int'(mem_raddr)) exp_rd_v = 1'b0;
            mram[lp] = host_in_data;
            mknown[lp] = 1'b1;
            lp++;
            if (lp == DEPTH) mfull = 1'b1;
          end
          if (host_start) phase = P_RUN;
        end
        P_RUN: begin
          if (mem_write) begin
            if (mem_waddr == mem_raddr) exp_rd_v = 1'b0;
            mram[mem_waddr] = mem_data_in;
            mknown[mem_waddr] = 1'b1;
          end
          if (cpu_halted) begin
            q.delete();
            s = 0;
            for (int i = 0; i < DLEN; i++) begin
              e = mram[(DBASE + i) % DEPTH];
              q.push_back(e);
              s += int'(e);
            end
`ifdef DUMP_CHECKSUM_EN
            q.push_back(8'(-s));
`endif
            rx_cnt = 0;
            phase = P_DUMP;
          end
        end
        P_DUMP: begin
          if (host_out_valid && host_out_ready) begin
            if (q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL dump_extra: got byte %0h want none", host_out_data);
            end else begin
              e = q.pop_front();
              chk("dump_byte", host_out_data, e);
            end
            if (rx_cnt < 128) rx[rx_cnt] = host_out_data;
            rx_cnt++;
            if (q.size() == 0) phase = P_DONE;
          end else if (host_out_valid) begin
            prev_hold = 1'b1;
            prev_data = host_out_data;
          end
        end
        default: begin
          if (host_start) begin
            phase = P_LOAD;
            lp = 0;
            mfull = 1'b0;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit with_start, output bit ok);
    int n = 0;
    ok = 1'b0;
    host_in_data  = b;
    host_in_valid = 1'b1;
    host_start    = with_start;
    while (n < 8 && !ok) begin
      @(negedge clk);
      if (host_in_ready) ok = 1'b1;
      tick();
      n++;
    end
    host_in_valid = 1'b0;
    host_start    = 1'b0;
  endtask

  task automatic pulse_start();
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
  endtask

  task automatic run_dump(input int mode);
    int n = 0;
    cpu_halted = 1'b1;
    tick();
    cpu_halted = 1'b0;
    while (phase != P_DONE && n < 3000) begin
      case (mode)
        0: host_out_ready = 1'b1;
        1: host_out_ready = ((n / 2) % 2) == 0;
        default: host_out_ready = 1'($urandom_range(0, 1));
      endcase
      tick();
      n++;
    end
    host_out_ready = 1'b0;
    if (n >= 3000) begin
      total++;
      bad++;
      $display("FAIL dump_timeout: got %0d bytes after %0d cycles want %0d", rx_cnt, n, EXP_N);
    end
    chk("dump_count", rx_cnt, EXP_N);
  endtask

  task automatic check_fixed_dump(input string tag);
    chk({tag, "_rx0"}, rx[0], 8'h00);
    chk({tag, "_rx10"}, rx[10], 8'h0A);
    chk({tag, "_rx63"}, rx[63], 8'h3F);
`ifdef DUMP_CHECKSUM_EN
    chk({tag, "_sum"}, rx[64], 8'h20);
`endif
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int acc;
    int n;
    tick();
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("lit_rst_in_ready", host_in_ready, 0);
    chk("lit_rst_cpu_reset", cpu_reset, 1);
    chk("lit_start_addr", cpu_start_address, 0);
    tick();
    @(negedge clk);
    chk("lit_idle_in_ready", host_in_ready, 1);

    // Program load; host_start rides with the last byte.
    tick();
    send_byte(8'hC2, 1'b0, ok);
    send_byte(8'h05, 1'b0, ok);
    send_byte(8'hFF, 1'b0, ok);
    send_byte(8'hFF, 1'b1, ok);
    @(negedge clk);
    chk("lit_run_cpu_reset", cpu_reset, 0);
    chk("lit_run_mem_ready", mem_ready, 1);
    tick();
    for (int a = 0; a < 4; a++) begin
      mem_raddr = AW'(a);
      tick();
    end
    mem_raddr = 9'd1;
    tick();
    @(negedge clk);
    chk("lit_rd1", mem_data_out, 8'h05);
    tick();
    mem_raddr = 9'd3;
    tick();
    @(negedge clk);
    chk("lit_rd3", mem_data_out, 8'hFF);
    tick();
    mem_write = 1'b1;
    mem_waddr = 9'h010;
    mem_data_in = 8'hAA;
    tick();
    mem_write = 1'b0;
    mem_raddr = 9'h010;
    tick();
    @(negedge clk);
    chk("lit_rd10", mem_data_out, 8'hAA);
    tick();

    // Preload dump window with 0..63 through CPU writes, then dump.
    for (int i = 0; i < DLEN; i++) begin
      mem_write = 1'b1;
      mem_waddr = AW'(DBASE + i);
      mem_data_in = 8'(i);
      tick();
    end
    mem_write = 1'b0;
    run_dump(0);
    check_fixed_dump("d0");

    // Same data, host_out_ready toggled every two cycles.
    pulse_start();
    pulse_start();
    run_dump(1);
    check_fixed_dump("d1");

    // Random load, random CPU traffic, random-ready dump.
    pulse_start();
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      send_byte(8'($urandom), 1'b0, ok);
    end
    pulse_start();
    for (int c = 0; c < 150; c++) begin
      mem_raddr   = AW'($urandom_range(0, 127));
      mem_write   = 1'($urandom_range(0, 1));
      mem_waddr   = AW'($urandom_range(0, 127));
      mem_data_in = 8'($urandom);
      tick();
    end
    mem_write = 1'b0;
    run_dump(2);

    // Overfill: 515 bytes offered, only 512 may land.
    pulse_start();
    acc = 0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      send_byte((i < DEPTH) ? (8'(i) ^ 8'h5A) : 8'hEE, 1'b0, ok);
      if (ok) acc++;
    end
    chk("lit_accepted", acc, 512);
    @(negedge clk);
    chk("lit_full_in_ready", host_in_ready, 0);
    tick();
    pulse_start();
    mem_raddr = 9'd0;
    tick();
    @(negedge clk);
    chk("lit_ram0_kept", mem_data_out, 8'h5A);
    tick();
    mem_raddr = 9'd511;
    tick();
    @(negedge clk);
    chk("lit_ram511", mem_data_out, 8'hA5);
    tick();

    // Reset while byte 10 of the dump is pending.
    cpu_halted = 1'b1;
    tick();
    cpu_halted = 1'b0;
    n = 0;
    while (!(rx_cnt == 10 && host_out_valid) && n < 500) begin
      host_out_ready = (rx_cnt < 10);
      tick();
      n++;
    end
    host_out_ready = 1'b0;
    chk("lit_pre_rst_rx", rx_cnt, 10);
    reset = 1'b1;
    tick();
    @(negedge clk);
    chk("lit_abort_valid", host_out_valid, 0);
    chk("lit_abort_cpu_reset", cpu_reset, 1);
    chk("lit_abort_mem_ready", mem_ready, 0);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("lit_abort_idle", host_in_ready, 1);
    tick();
    pulse_start();
    mem_raddr = 9'd2;
    tick();
    @(negedge clk);
    chk("lit_kept_ram2", mem_data_out, 8'h58);
    tick();
    for (int a = 3; a < 6; a++) begin
      mem_raddr = AW'(a);
      tick();
    end
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
